// File: rtl/rr_stats_pkg.sv
// Shared definitions for the rr_stats beat-statistics stage: FSM states,
// heart-rate divider constants and the output saturation helper.
package rr_stats_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UPDATE,
    ST_AVG,
    ST_DIV,
    ST_DONE
  } rr_state_e;

  // Quotient bits needed for a numerator n (one divider step per bit).
  function automatic int unsigned num_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned RR_FS_DEFAULT = 360;
  localparam int unsigned RR_NUMERATOR  = 60 * RR_FS_DEFAULT;
  localparam int unsigned RR_NUM_W      = num_width(RR_NUMERATOR);

  function automatic logic [31:0] sat_unsigned(input logic [31:0] value,
                                               input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (value > max_v) ? max_v : value;
  endfunction

endpackage

// File: rtl/rr_stats_seq_divider.sv
// Restoring unsigned divider, one quotient bit per enabled clock.
// done is high in the cycle whose closing edge produces the last quotient bit.
module seq_divider #(
  parameter int unsigned NUM_W = 15,
  parameter int unsigned DEN_W = 11
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             ce,
  input  logic             start,
  input  logic [NUM_W-1:0] numerator,
  input  logic [DEN_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quotient
);

  localparam int unsigned CNT_W = $clog2(NUM_W + 1);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_W-1:0] nq_q, nq_d;
  logic [DEN_W-1:0] rem_q, rem_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [DEN_W:0]   trial;
  logic             last_step;

  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    nq_d      = nq_q;
    rem_d     = rem_q;
    den_d     = den_q;
    trial     = {rem_q, nq_q[NUM_W-1]};
    last_step = busy_q && (cnt_q == CNT_W'(NUM_W - 1));
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      nq_d   = numerator;
      rem_d  = '0;
      den_d  = divisor;
    end else if (busy_q) begin
      // Numerator bits shift out of nq while quotient bits shift in.
      if (trial >= {1'b0, den_q}) begin
        rem_d = DEN_W'(trial - {1'b0, den_q});
        nq_d  = {nq_q[NUM_W-2:0], 1'b1};
      end else begin
        rem_d = trial[DEN_W-1:0];
        nq_d  = {nq_q[NUM_W-2:0], 1'b0};
      end
      cnt_d = cnt_q + CNT_W'(1);
      if (last_step) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      nq_q   <= '0;
      rem_q  <= '0;
      den_q  <= '0;
    end else if (ce) begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      nq_q   <= nq_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
    end
  end

  assign busy     = busy_q;
  assign done     = last_step && ce;
  assign quotient = nq_q;

endmodule

// File: rtl/rr_stats.sv
// RR-interval statistics: validation, windowed running mean, irregular-beat
// flag and heart rate via a sequential divider. One beat in flight, one queued.
module rr_stats
  import rr_stats_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 11,
  parameter int unsigned FS         = 360,
  parameter int unsigned AVG_LEN    = 8,
  parameter int unsigned HR_WIDTH   = 8,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned RR_MIN     = 72,
  parameter int unsigned RR_MAX     = 1080
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  ce,
  input  logic [DATA_WIDTH-1:0] rr_period,
  input  logic                  rr_period_updated,
  output logic [HR_WIDTH-1:0]   heart_rate,
  output logic [DATA_WIDTH-1:0] avg_rr,
  output logic                  hr_valid,
  output logic                  irregular,
  output logic                  artifact,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic                  overrun
);

  localparam int unsigned NUMER     = 60 * FS;
  localparam int unsigned NUM_W     = num_width(NUMER);
  localparam int unsigned AVG_SHIFT = $clog2(AVG_LEN);
  localparam int unsigned SUM_W     = DATA_WIDTH + AVG_SHIFT;
  localparam logic [DATA_WIDTH-1:0] RR_MIN_V = DATA_WIDTH'(RR_MIN);
  localparam logic [DATA_WIDTH-1:0] RR_MAX_V = DATA_WIDTH'(RR_MAX);

  rr_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] work_q, work_d;
  logic [DATA_WIDTH-1:0] pend_q, pend_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [DATA_WIDTH-1:0] win_q [AVG_LEN];
  logic [DATA_WIDTH-1:0] win_d [AVG_LEN];
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [AVG_SHIFT-1:0]  wr_ptr_q, wr_ptr_d;
  logic                  primed_q, primed_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  irr_next_q, irr_next_d;
  logic [DATA_WIDTH-1:0] avg_calc_q, avg_calc_d;
  logic [HR_WIDTH-1:0]   hr_q, hr_d;
  logic [DATA_WIDTH-1:0] avg_q, avg_d;
  logic                  irr_q, irr_d;
  logic                  ovr_q, ovr_d;
  logic                  hv_q, hv_d;
  logic                  art_q, art_d;

  logic                  rr_ok;
  logic [DATA_WIDTH-1:0] rr_dev;
  logic [DATA_WIDTH-1:0] dev_thr;
  logic                  div_start;
  logic                  div_busy;
  logic                  div_done;
  logic [NUM_W-1:0]      div_quot;

  seq_divider #(
    .NUM_W(NUM_W),
    .DEN_W(DATA_WIDTH)
  ) u_div (
    .clk      (clk),
    .nrst     (nrst),
    .ce       (ce),
    .start    (div_start),
    .numerator(NUM_W'(NUMER)),
    .divisor  (sum_q[SUM_W-1:AVG_SHIFT]),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

  always_comb begin
    state_d      = state_q;
    work_d       = work_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    win_d        = win_q;
    sum_d        = sum_q;
    wr_ptr_d     = wr_ptr_q;
    primed_d     = primed_q;
    cnt_d        = cnt_q;
    irr_next_d   = irr_next_q;
    avg_calc_d   = avg_calc_q;
    hr_d         = hr_q;
    avg_d        = avg_q;
    irr_d        = irr_q;
    ovr_d        = ovr_q;
    div_start    = 1'b0;
    hv_d         = 1'b0;
    art_d        = 1'b0;

    rr_ok   = (work_q >= RR_MIN_V) && (work_q <= RR_MAX_V);
    rr_dev  = (work_q >= avg_q) ? (work_q - avg_q) : (avg_q - work_q);
    dev_thr = avg_q >> 3;

    // A strobe arriving mid-beat is queued once; a second one is lost.
    if (rr_period_updated && (state_q != ST_IDLE)) begin
      if (!pend_valid_q) begin
        pend_d       = rr_period;
        pend_valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (pend_valid_q) begin
          work_d       = pend_q;
          pend_valid_d = 1'b0;
          state_d      = ST_UPDATE;
          if (rr_period_updated) begin
            pend_d       = rr_period;
            pend_valid_d = 1'b1;
          end
        end else if (rr_period_updated) begin
          work_d  = rr_period;
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        if (!rr_ok) begin
          art_d   = ce;
          state_d = ST_IDLE;
        end else begin
          irr_next_d = primed_q && (rr_dev > dev_thr);
          if (!primed_q) begin
            for (int unsigned i = 0; i < AVG_LEN; i++) win_d[i] = work_q;
            sum_d    = {work_q, {AVG_SHIFT{1'b0}}};
            primed_d = 1'b1;
          end else begin
            sum_d = sum_q + {{AVG_SHIFT{1'b0}}, work_q}
                          - {{AVG_SHIFT{1'b0}}, win_q[wr_ptr_q]};
            win_d[wr_ptr_q] = work_q;
            wr_ptr_d = wr_ptr_q + AVG_SHIFT'(1);
          end
          if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
          state_d = ST_AVG;
        end
      end
      ST_AVG: begin
        avg_calc_d = sum_q[SUM_W-1:AVG_SHIFT];
        div_start  = 1'b1;
        state_d    = ST_DIV;
      end
      ST_DIV: begin
        if (div_done || !div_busy) state_d = ST_DONE;
      end
      ST_DONE: begin
        hr_d    = HR_WIDTH'(sat_unsigned(32'(div_quot), HR_WIDTH));
        avg_d   = avg_calc_q;
        irr_d   = irr_next_q;
        hv_d    = ce;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= ST_IDLE;
      work_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      for (int unsigned i = 0; i < AVG_LEN; i++) win_q[i] <= '0;
      sum_q        <= '0;
      wr_ptr_q     <= '0;
      primed_q     <= 1'b0;
      cnt_q        <= '0;
      irr_next_q   <= 1'b0;
      avg_calc_q   <= '0;
      hr_q         <= '0;
      avg_q        <= '0;
      irr_q        <= 1'b0;
      ovr_q        <= 1'b0;
    end else if (ce) begin
      state_q      <= state_d;
      work_q       <= work_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      win_q        <= win_d;
      sum_q        <= sum_d;
      wr_ptr_q     <= wr_ptr_d;
      primed_q     <= primed_d;
      cnt_q        <= cnt_d;
      irr_next_q   <= irr_next_d;
      avg_calc_q   <= avg_calc_d;
      hr_q         <= hr_d;
      avg_q        <= avg_d;
      irr_q        <= irr_d;
      ovr_q        <= ovr_d;
    end
  end

  // Pulse registers run every edge so a pulse cannot be stretched by ce.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hv_q  <= 1'b0;
      art_q <= 1'b0;
    end else begin
      hv_q  <= hv_d;
      art_q <= art_d;
    end
  end

  assign heart_rate = hr_q;
  assign avg_rr     = avg_q;
  assign hr_valid   = hv_q && ce;
  assign irregular  = irr_q;
  assign artifact   = art_q && ce;
  assign beat_count = cnt_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_rr_stats.sv
// Self-checking bench for rr_stats: fixed vectors, corner-case sequences and
// randomized beats against a queue-based reference model.
module tb_rr_stats;

  localparam int DW     = 11;
  localparam int HW     = 8;
  localparam int CW     = 16;
  localparam int RMIN   = 72;
  localparam int RMAX   = 1080;
  localparam int NUMER  = 21600;
  localparam int WIN    = 8;

  logic          clk = 1'b0;
  logic          nrst, ce, upd;
  logic [DW-1:0] rr;
  logic [HW-1:0] hr;
  logic [DW-1:0] avg;
  logic          hv, irr, art, ovr;
  logic [CW-1:0] cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rr_stats #(
    .DATA_WIDTH(DW),
    .FS        (360),
    .AVG_LEN   (WIN),
    .HR_WIDTH  (HW),
    .CNT_WIDTH (CW),
    .RR_MIN    (RMIN),
    .RR_MAX    (RMAX)
  ) dut (
    .clk              (clk),
    .nrst             (nrst),
    .ce               (ce),
    .rr_period        (rr),
    .rr_period_updated(upd),
    .heart_rate       (hr),
    .avg_rr           (avg),
    .hr_valid         (hv),
    .irregular        (irr),
    .artifact         (art),
    .beat_count       (cnt),
    .overrun          (ovr)
  );

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference model: window kept as a queue of the most recent accepted beats.
  int m_win[$];
  bit m_primed;
  int m_avg, m_hr, m_irr, m_cnt;

  function automatic void model_reset();
    m_win.delete();
    m_primed = 0;
    m_avg = 0; m_hr = 0; m_irr = 0; m_cnt = 0;
  endfunction

  function automatic bit model_beat(input int r);
    int sum, d, q;
    if (r < RMIN || r > RMAX) return 1'b1;
    d = (r > m_avg) ? r - m_avg : m_avg - r;
    m_irr = (m_primed && (d > m_avg / 8)) ? 1 : 0;
    if (!m_primed) begin
      repeat (WIN) m_win.push_back(r);
      m_primed = 1;
    end else begin
      void'(m_win.pop_front());
      m_win.push_back(r);
    end
    sum = 0;
    foreach (m_win[j]) sum += m_win[j];
    m_avg = sum / WIN;
    q = NUMER / m_avg;
    m_hr = (q > 255) ? 255 : q;
    if (m_cnt < 65535) m_cnt++;
    return 1'b0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0; upd = 1'b0; ce = 1'b1; rr = '0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  // Called at a negedge; index i means "observed just after edge E_i".
  task automatic run_beat(input int r, input int ncyc, output int hv_at,
                          output int art_at, output int hv_n, output int art_n);
    hv_at = -1; art_at = -1; hv_n = 0; art_n = 0;
    rr  = DW'(r);
    upd = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (i == 0) upd = 1'b0;
      if (hv) begin hv_n++; if (hv_at < 0) hv_at = i; end
      if (art) begin art_n++; if (art_at < 0) art_at = i; end
    end
  endtask

  typedef struct {
    bit rst;
    int rr;
    int art_at;
    int hv_at;
    int hr;
    int avg;
    int irr;
    int cnt;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int hva, arta, hvn, artn, r, pick;
    bit exp_art;

    nrst = 1'b0; ce = 1'b1; upd = 1'b0; rr = '0;
    #12;
    check("rst_hr", int'(hr), 0);
    check("rst_avg", int'(avg), 0);
    check("rst_hv", int'(hv), 0);
    check("rst_irr", int'(irr), 0);
    check("rst_art", int'(art), 0);
    check("rst_cnt", int'(cnt), 0);
    check("rst_ovr", int'(ovr), 0);

    //            rst  rr    art  hv   hr   avg   irr cnt
    tbl[0] = '{1'b1, 360,  -1,  18,  60,  360,  0,  1};
    tbl[1] = '{1'b0, 50,    1,  -1,  60,  360,  0,  1};
    tbl[2] = '{1'b0, 1081,  1,  -1,  60,  360,  0,  1};
    tbl[3] = '{1'b1, 300,  -1,  18,  72,  300,  0,  1};
    tbl[4] = '{1'b0, 360,  -1,  18,  70,  307,  1,  2};
    tbl[5] = '{1'b0, 307,  -1,  18,  70,  308,  0,  3};
    tbl[6] = '{1'b1, 72,   -1,  18,  255, 72,   0,  1};
    tbl[7] = '{1'b0, 71,    1,  -1,  255, 72,   0,  1};
    tbl[8] = '{1'b1, 1080, -1,  18,  20,  1080, 0,  1};
    tbl[9] = '{1'b0, 1081,  1,  -1,  20,  1080, 0,  1};

    for (int k = 0; k < 10; k++) begin
      if (tbl[k].rst) do_reset();
      run_beat(tbl[k].rr, 24, hva, arta, hvn, artn);
      check($sformatf("v%0d_art_at", k), arta, tbl[k].art_at);
      check($sformatf("v%0d_art_n", k), artn, (tbl[k].art_at >= 0) ? 1 : 0);
      check($sformatf("v%0d_hv_at", k), hva, tbl[k].hv_at);
      check($sformatf("v%0d_hv_n", k), hvn, (tbl[k].hv_at >= 0) ? 1 : 0);
      check($sformatf("v%0d_hr", k), int'(hr), tbl[k].hr);
      check($sformatf("v%0d_avg", k), int'(avg), tbl[k].avg);
      check($sformatf("v%0d_irr", k), int'(irr), tbl[k].irr);
      check($sformatf("v%0d_cnt", k), int'(cnt), tbl[k].cnt);
    end
    check("tbl_ovr", int'(ovr), 0);

    // Three strobes three cycles apart: first served, second queued, third lost.
    do_reset();
    rr = DW'(360); upd = 1'b1; hvn = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      upd = (i == 2) || (i == 5);
      rr  = (i == 2) ? DW'(300) : DW'(400);
      if (hv) begin
        hvn++;
        if (hvn == 1) begin
          check("ovr_p1_at", i, 18);
          check("ovr_p1_hr", int'(hr), 60);
          check("ovr_p1_avg", int'(avg), 360);
        end else if (hvn == 2) begin
          check("ovr_p2_at", i, 37);
          check("ovr_p2_hr", int'(hr), 61);
          check("ovr_p2_avg", int'(avg), 352);
          check("ovr_p2_irr", int'(irr), 1);
        end
      end
    end
    check("ovr_pulses", hvn, 2);
    check("ovr_flag", int'(ovr), 1);
    check("ovr_cnt", int'(cnt), 2);

    // Asynchronous reset in the middle of the divide aborts the beat.
    rr = DW'(360); upd = 1'b1; hvn = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i == 0) upd = 1'b0;
      if (i == 7) begin
        nrst = 1'b0;
        #1;
        check("arst_hr", int'(hr), 0);
        check("arst_avg", int'(avg), 0);
        check("arst_cnt", int'(cnt), 0);
        check("arst_irr", int'(irr), 0);
        check("arst_ovr", int'(ovr), 0);
      end
      if (i == 9) nrst = 1'b1;
      if (hv) hvn++;
    end
    check("arst_no_hv", hvn, 0);
    model_reset();
    run_beat(360, 24, hva, arta, hvn, artn);
    check("arst_re_hv_at", hva, 18);
    check("arst_re_hr", int'(hr), 60);
    check("arst_re_avg", int'(avg), 360);
    check("arst_re_cnt", int'(cnt), 1);

    // ce low for ten edges mid-divide; a strobe seen while ce is low is ignored.
    do_reset();
    rr = DW'(360); upd = 1'b1; hvn = 0; hva = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      upd = (i == 8);
      if (i == 8) rr = DW'(500);
      if (i == 4) ce = 1'b0;
      if (i == 14) ce = 1'b1;
      if (hv) begin hvn++; if (hva < 0) hva = i; end
    end
    check("ce_hv_at", hva, 28);
    check("ce_hv_n", hvn, 1);
    check("ce_hr", int'(hr), 60);
    check("ce_avg", int'(avg), 360);
    check("ce_irr", int'(irr), 0);
    check("ce_cnt", int'(cnt), 1);
    check("ce_ovr", int'(ovr), 0);

    // Randomized beats against the reference model.
    do_reset();
    for (int n = 0; n < 80; n++) begin
      pick = int'($urandom_range(0, 3));
      if (pick == 0) begin
        r = int'($urandom_range(40, 1120));
      end else if (pick == 3) begin
        case ($urandom_range(0, 3))
          0: r = RMIN - 1;
          1: r = RMIN;
          2: r = RMAX;
          default: r = RMAX + 1;
        endcase
      end else if (m_primed) begin
        r = m_avg - m_avg / 6 + int'($urandom_range(0, m_avg / 3));
      end else begin
        r = 360;
      end
      if (r < 1) r = 1;
      if (r > 2047) r = 2047;
      exp_art = model_beat(r);
      run_beat(r, 22, hva, arta, hvn, artn);
      check($sformatf("rnd%0d_art_at(rr=%0d)", n, r), arta, exp_art ? 1 : -1);
      check($sformatf("rnd%0d_hv_at(rr=%0d)", n, r), hva, exp_art ? -1 : 18);
      check($sformatf("rnd%0d_hr(rr=%0d)", n, r), int'(hr), m_hr);
      check($sformatf("rnd%0d_avg(rr=%0d)", n, r), int'(avg), m_avg);
      check($sformatf("rnd%0d_irr(rr=%0d)", n, r), int'(irr), m_irr);
      check($sformatf("rnd%0d_cnt(rr=%0d)", n, r), int'(cnt), m_cnt);
    end
    check("rnd_ovr", int'(ovr), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
